// File: rtl/cache_refill_ctrl.sv
// Miss handler for the 4-set, 2-way data cache: optional dirty write-back, single-word refill, one-cycle fill.
// Defining CACHE_WRITEBACK_EN builds the WB phase; left undefined, every miss is a plain read (write-through cache).
module cache_refill_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_W      = 27,
   parameter int SET_W      = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  miss_valid,
   input  logic [DATA_WIDTH-1:0] miss_addr,
   input  logic                  evict_dirty,
   input  logic [DATA_WIDTH-1:0] evict_addr,
   input  logic [DATA_WIDTH-1:0] evict_data,
   output logic                  stall,
   output logic                  fill_valid,
   output logic [SET_W-1:0]      fill_set,
   output logic [TAG_W-1:0]      fill_tag,
   output logic [DATA_WIDTH-1:0] fill_data,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, WB, RD, FILL} state_t;

   state_t                state;
   logic [DATA_WIDTH-1:2] miss_word;
   logic                  unused_bits;

   function automatic logic [DATA_WIDTH-1:0] word_addr(input logic [DATA_WIDTH-1:2] w);
      return {w, 2'b00};
   endfunction

   // Byte-offset bits never reach memory; evict ports are dead without the write-back phase.
`ifdef CACHE_WRITEBACK_EN
   assign unused_bits = ^{miss_addr[1:0], evict_addr[1:0]};
`else
   assign unused_bits = ^{miss_addr[1:0], evict_dirty, evict_addr, evict_data};
`endif

   assign stall = miss_valid || (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         miss_word  <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         fill_valid <= 1'b0;
         fill_set   <= '0;
         fill_tag   <= '0;
         fill_data  <= '0;
      end else begin
         fill_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (miss_valid) begin
                  miss_word <= miss_addr[DATA_WIDTH-1:2];
                  mem_req   <= 1'b1;
`ifdef CACHE_WRITEBACK_EN
                  if (evict_dirty) begin
                     state     <= WB;
                     mem_we    <= 1'b1;
                     mem_addr  <= word_addr(evict_addr[DATA_WIDTH-1:2]);
                     mem_wdata <= evict_data;
                  end else begin
                     state    <= RD;
                     mem_we   <= 1'b0;
                     mem_addr <= word_addr(miss_addr[DATA_WIDTH-1:2]);
                  end
`else
                  state    <= RD;
                  mem_we   <= 1'b0;
                  mem_addr <= word_addr(miss_addr[DATA_WIDTH-1:2]);
`endif
               end
            end
`ifdef CACHE_WRITEBACK_EN
            WB: begin
               // Read request follows the write ack back-to-back, mem_req never drops.
               if (mem_ack) begin
                  state    <= RD;
                  mem_we   <= 1'b0;
                  mem_addr <= word_addr(miss_word);
               end
            end
`endif
            RD: begin
               if (mem_ack) begin
                  state      <= FILL;
                  mem_req    <= 1'b0;
                  fill_valid <= 1'b1;
                  fill_data  <= mem_rdata;
                  fill_set   <= miss_word[SET_W+2:3];
                  fill_tag   <= miss_word[DATA_WIDTH-1:SET_W+3];
               end
            end
            FILL: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: a per-cycle expected timeline is built from miss descriptions, then replayed and compared.
module tb_cache_refill_ctrl;

`ifdef CACHE_WRITEBACK_EN
   localparam bit WB_EN = 1'b1;
`else
   localparam bit WB_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        miss_valid;
   logic [31:0] miss_addr;
   logic        evict_dirty;
   logic [31:0] evict_addr;
   logic [31:0] evict_data;
   logic        stall;
   logic        fill_valid;
   logic [1:0]  fill_set;
   logic [26:0] fill_tag;
   logic [31:0] fill_data;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   cache_refill_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .miss_valid (miss_valid),
      .miss_addr  (miss_addr),
      .evict_dirty(evict_dirty),
      .evict_addr (evict_addr),
      .evict_data (evict_data),
      .stall      (stall),
      .fill_valid (fill_valid),
      .fill_set   (fill_set),
      .fill_tag   (fill_tag),
      .fill_data  (fill_data),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
   );

   typedef struct {
      bit          rst_n;
      bit          miss_valid;
      logic [31:0] miss_addr;
      bit          evict_dirty;
      logic [31:0] evict_addr;
      logic [31:0] evict_data;
      bit          mem_ack;
      logic [31:0] mem_rdata;
      bit          live;
      bit          e_rstvals;
      bit          e_stall;
      bit          e_req;
      bit          e_we;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      bit          e_fill;
      logic [1:0]  e_set;
      logic [26:0] e_tag;
      logic [31:0] e_fdata;
   } cyc_t;

   cyc_t sched[256];
   int   ncyc = 0;
   bit   built = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   clean_start, dirty_start, abort_start, post_start, a_start, b_start, hold_start;

   function automatic cyc_t base();
      cyc_t e;
      e.rst_n = 1'b1;       e.miss_valid = 1'b0;  e.miss_addr = '0;
      e.evict_dirty = 1'b0; e.evict_addr = '0;    e.evict_data = '0;
      e.mem_ack = 1'b0;     e.mem_rdata = 32'h0BAD_0BAD;
      e.live = 1'b1;        e.e_rstvals = 1'b0;   e.e_stall = 1'b0;
      e.e_req = 1'b0;       e.e_we = 1'b0;        e.e_addr = '0;  e.e_wdata = '0;
      e.e_fill = 1'b0;      e.e_set = '0;         e.e_tag = '0;   e.e_fdata = '0;
      return e;
   endfunction

   task automatic put(input cyc_t e);
      sched[ncyc] = e;
      ncyc++;
   endtask

   task automatic idle(input int n, input bit ack);
      cyc_t e;
      for (int i = 0; i < n; i++) begin
         e = base();
         e.mem_ack   = ack;
         e.mem_rdata = 32'hFFFF_0000 ^ i;
         put(e);
      end
   endtask

   // One miss as seen from outside: request cycle, optional write phase (dw wait cycles),
   // read phase (dr wait cycles), then one fill cycle. abort >= 0 resets at that read-cycle index.
   task automatic miss(input logic [31:0] ma, input bit dirty, input logic [31:0] ea,
                       input logic [31:0] ed, input int dw, input int dr, input logic [31:0] rd,
                       input int abort, input bit hold, output int start);
      cyc_t e;
      start = ncyc;
      e = base();
      e.miss_valid = 1'b1; e.miss_addr = ma; e.evict_dirty = dirty;
      e.evict_addr = ea;   e.evict_data = ed; e.mem_ack = 1'b1; e.e_stall = 1'b1;
      put(e);
      if (dirty && WB_EN) begin
         for (int i = 0; i <= dw; i++) begin
            e = base();
            e.mem_ack = hold || (i == dw);
            e.e_req = 1'b1; e.e_we = 1'b1; e.e_addr = {ea[31:2], 2'b00}; e.e_wdata = ed;
            e.e_stall = 1'b1;
            put(e);
         end
      end
      for (int i = 0; i <= dr; i++) begin
         e = base();
         e.e_req = 1'b1; e.e_addr = {ma[31:2], 2'b00}; e.e_stall = 1'b1;
         e.mem_ack   = hold || (i == dr);
         e.mem_rdata = (i == dr) ? rd : ~rd;
         if (i == 0) begin
            e.miss_valid = 1'b1;
            e.miss_addr  = ma ^ 32'h0000_0F18;
         end
         if (i == abort) begin
            e.rst_n = 1'b0; e.mem_ack = 1'b0;
            put(e);
            e = base();
            e.e_rstvals = 1'b1;
            put(e);
            return;
         end
         put(e);
      end
      e = base();
      e.mem_ack = hold;
      e.e_fill = 1'b1; e.e_set = ma[4:3]; e.e_tag = ma[31:5]; e.e_fdata = rd; e.e_stall = 1'b1;
      put(e);
   endtask

   task automatic build_schedule();
      cyc_t e;
      e = base(); e.rst_n = 1'b0; e.miss_valid = 1'b1; e.live = 1'b0; put(e);
      e = base(); e.rst_n = 1'b0; e.mem_ack = 1'b1; e.e_rstvals = 1'b1; put(e);
      e = base(); e.rst_n = 1'b0; e.miss_valid = 1'b1; e.miss_addr = 32'h0000_1018;
      e.e_rstvals = 1'b1; e.e_stall = 1'b1; put(e);
      e = base(); e.mem_ack = 1'b1; e.e_rstvals = 1'b1; put(e);
      idle(1, 1'b0);
      idle(2, 1'b1);
      idle(1, 1'b0);
      miss(32'h0000_1018, 1'b0, 32'h0, 32'h0, 0, 3, 32'hDEAD_BEEF, -1, 1'b0, clean_start);
      idle(2, 1'b0);
      miss(32'h0000_3008, 1'b1, 32'h0000_2008, 32'h1234_5678, 1, 0, 32'h600D_F00D, -1, 1'b0, dirty_start);
      idle(2, 1'b0);
      miss(32'h0000_4ABC, 1'b0, 32'h0, 32'h0, 0, 5, 32'h0, 2, 1'b0, abort_start);
      idle(1, 1'b1);
      idle(1, 1'b0);
      miss(32'h0000_5010, 1'b0, 32'h0, 32'h0, 0, 0, 32'hCAFE_F00D, -1, 1'b0, post_start);
      idle(1, 1'b0);
      miss(32'h0000_6003, 1'b0, 32'h0, 32'h0, 0, 1, 32'h1111_1111, -1, 1'b0, a_start);
      miss(32'h0000_7FF8, 1'b0, 32'h0, 32'h0, 0, 1, 32'h2222_2222, -1, 1'b0, b_start);
      idle(2, 1'b0);
      idle(1, 1'b1);
      miss(32'h0000_9018, 1'b1, 32'h0000_A010, 32'h5555_AAAA, 0, 0, 32'h0F0F_0F0F, -1, 1'b1, hold_start);
      idle(2, 1'b1);
      idle(2, 1'b0);
   endtask

   task automatic apply(input int n);
      rst_n       = sched[n].rst_n;
      miss_valid  = sched[n].miss_valid;
      miss_addr   = sched[n].miss_addr;
      evict_dirty = sched[n].evict_dirty;
      evict_addr  = sched[n].evict_addr;
      evict_data  = sched[n].evict_data;
      mem_ack     = sched[n].mem_ack;
      mem_rdata   = sched[n].mem_rdata;
   endtask

   task automatic check(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, n, act, exp);
      end
   endtask

   initial begin
      build_schedule();
      built = 1'b1;
      apply(0);
      for (int n = 1; n < ncyc; n++) begin
         @(posedge clk);
         #1;
         apply(n);
      end
   end

   initial begin
      wait (built);
      for (int n = 1; n < ncyc; n++) begin
         @(negedge clk);
         if (sched[n].live) begin
            check("stall", n, 32'(stall), 32'(sched[n].e_stall));
            if (sched[n].e_rstvals) begin
               check("rst_mem_req", n, 32'(mem_req), 32'd0);
               check("rst_mem_we", n, 32'(mem_we), 32'd0);
               check("rst_mem_addr", n, mem_addr, 32'd0);
               check("rst_mem_wdata", n, mem_wdata, 32'd0);
               check("rst_fill_valid", n, 32'(fill_valid), 32'd0);
               check("rst_fill_set", n, 32'(fill_set), 32'd0);
               check("rst_fill_tag", n, 32'(fill_tag), 32'd0);
               check("rst_fill_data", n, fill_data, 32'd0);
            end else begin
               check("mem_req", n, 32'(mem_req), 32'(sched[n].e_req));
               check("fill_valid", n, 32'(fill_valid), 32'(sched[n].e_fill));
               if (sched[n].e_req) begin
                  check("mem_we", n, 32'(mem_we), 32'(sched[n].e_we));
                  check("mem_addr", n, mem_addr, sched[n].e_addr);
                  if (sched[n].e_we) check("mem_wdata", n, mem_wdata, sched[n].e_wdata);
               end
               if (sched[n].e_fill) begin
                  check("fill_set", n, 32'(fill_set), 32'(sched[n].e_set));
                  check("fill_tag", n, 32'(fill_tag), 32'(sched[n].e_tag));
                  check("fill_data", n, fill_data, sched[n].e_fdata);
               end
            end
         end
         if (n == clean_start + 1) begin
            check("pin_clean_addr", n, mem_addr, 32'h0000_1018);
            check("pin_clean_we", n, 32'(mem_we), 32'd0);
         end
         if (n == clean_start + 5) begin
            check("pin_clean_fill", n, 32'(fill_valid), 32'd1);
            check("pin_clean_set", n, 32'(fill_set), 32'd3);
            check("pin_clean_tag", n, 32'(fill_tag), 32'h80);
            check("pin_clean_data", n, fill_data, 32'hDEAD_BEEF);
         end
         if (n == clean_start + 6) check("pin_clean_stall_low", n, 32'(stall), 32'd0);
         if (n == dirty_start + 1) begin
            check("pin_dirty_first_we", n, 32'(mem_we), WB_EN ? 32'd1 : 32'd0);
            check("pin_dirty_first_addr", n, mem_addr, WB_EN ? 32'h0000_2008 : 32'h0000_3008);
         end
         if (n == dirty_start + (WB_EN ? 4 : 2)) begin
            check("pin_dirty_fill", n, 32'(fill_valid), 32'd1);
            check("pin_dirty_set", n, 32'(fill_set), 32'd1);
         end
         if (n == abort_start + 4) check("pin_abort_req_low", n, 32'(mem_req), 32'd0);
         if (n == post_start + 2) check("pin_post_data", n, fill_data, 32'hCAFE_F00D);
         if (n == a_start + 1) check("pin_align_addr", n, mem_addr, 32'h0000_6000);
         if (n == b_start + 3) begin
            check("pin_b2b_fill", n, 32'(fill_valid), 32'd1);
            check("pin_b2b_data", n, fill_data, 32'h2222_2222);
         end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss handler for the 4-set, 2-way data cache: it is the memory-side counterpart that services cache misses. On a miss it optionally writes back a dirty victim, then fetches the missing word from main memory over a valid/ack handshake and returns it to the cache as a one-cycle fill. While a miss is in service it stalls the pipeline.

## Interface

Parameters:
- DATA_WIDTH, 32, data and address width.
- TAG_W, 27, tag width, address bits [31:5].
- SET_W, 2, set index width, address bits [4:3].

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- miss_valid  input  1  cache reports a miss on miss_addr.
- miss_addr  input  DATA_WIDTH  byte address that missed.
- evict_dirty  input  1  victim way is valid and dirty. Sampled with miss_valid.
- evict_addr  input  DATA_WIDTH  victim byte address.
- evict_data  input  DATA_WIDTH  victim data.
- stall  output  1  pipeline hold.
- fill_valid  output  1  one-cycle fill strobe to cache.
- fill_set  output  SET_W  set to fill.
- fill_tag  output  TAG_W  tag to install.
- fill_data  output  DATA_WIDTH  fetched word.
- mem_req  output  1  memory request valid.
- mem_we  output  1  1 = write-back, 0 = read.
- mem_addr  output  DATA_WIDTH  word-aligned address: {addr[31:2],2'b00}.
- mem_wdata  output  DATA_WIDTH  write-back data.
- mem_ack  input  1  memory completes the current request. Read data is valid in the same cycle.
- mem_rdata  input  DATA_WIDTH  read data.

## Operation

- FSM states: IDLE, WB, RD, FILL.
- IDLE:
  - If miss_valid is high, latch miss_addr.
  - Also latch evict_addr and evict_data when evict_dirty is high.
  - Next state is WB if evict_dirty is high, otherwise RD.
- WB:
  - mem_req=1, mem_we=1, mem_addr from the latched evict_addr, mem_wdata from the latched evict_data.
  - On mem_ack, go to RD.
- RD:
  - mem_req=1, mem_we=0, mem_addr from the latched miss_addr.
  - On mem_ack, register mem_rdata into fill_data and go to FILL.
- FILL:
  - fill_valid=1.
  - fill_set = latched miss_addr[4:3]; fill_tag = latched miss_addr[31:5].
  - Go to IDLE unconditionally.
- stall = miss_valid || (state != IDLE). This is combinational, so the pipeline stalls in the same cycle the miss appears.
- In the cycle the FSM returns to IDLE, stall depends only on miss_valid. The cache hits after the fill, so a miss_valid held high re-triggers only on a genuine second miss.
- Way selection and the LRU update belong to the cache. This block supplies only set, tag and data.
- mem_req, mem_we, mem_addr and mem_wdata are registered outputs. They must stay stable from assertion until the cycle mem_ack is sampled high.
- mem_ack is ignored when mem_req=0.
- Miss inputs arriving outside IDLE are ignored; stall already holds the requester.
- Reset values:
  - state=IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - fill_valid=0, fill_set=0, fill_tag=0, fill_data=0.
  - stall equals miss_valid.
- Reset in any state: return to IDLE next edge and drop mem_req. No fill is issued and latched data is discarded. Memory must tolerate an abandoned request.

## Timing

- Clean miss: miss_valid at cycle 0, mem_req rises at cycle 1.
- Acknowledge at cycle k gives fill_valid at cycle k+1 and the FSM back in IDLE at cycle k+2.
- Minimum clean-miss latency, with mem_ack in the first request cycle: fill at cycle 2.
- Dirty miss: the write phase adds (ack wait + 1) cycles.
- The read request is issued the cycle after the write ack; mem_req deasserts for zero cycles between WB and RD.
- fill_valid is high for exactly one cycle per serviced miss.
- mem_ack held high continuously: each phase completes in one cycle.

## Configuration

- CACHE_WRITEBACK_EN defined:
  - WB state present; dirty victims are written before the refill.
- CACHE_WRITEBACK_EN undefined:
  - WB state, evict latches and evict_* use are compiled out.
  - evict_dirty is ignored and mem_we is tied to 0.
  - Every miss goes IDLE to RD, for a write-through cache.

## Test plan

- Reset: rst_n=0 for 2 cycles, with mem_ack and miss_valid toggling.
  - Required: mem_req=0 and fill_valid=0 throughout.
  - Required: stall follows miss_valid only.
- Clean miss:
  - Stimulus: miss_addr=0x0000_1018, mem_ack 3 cycles after mem_req rises, mem_rdata=0xDEAD_BEEF.
  - Required: mem_addr=0x0000_1018, mem_we=0.
  - Required: fill_valid one cycle with fill_set=3, fill_tag=0x80, fill_data=0xDEAD_BEEF.
  - Required: stall low the cycle after.
- Dirty miss (macro on):
  - Stimulus: evict_dirty=1, evict_addr=0x0000_2008, evict_data=0x1234_5678, miss_addr=0x0000_3008.
  - Required: write 0x1234_5678 to 0x2008 first, then a read of 0x3008.
  - Required: fill_set=1.
- Same dirty stimulus with the macro off:
  - Required: only a read is issued; mem_we never high.
- Reset mid-RD, with mem_req high:
  - Required: mem_req low next edge and no fill_valid.
  - Required: a subsequent miss is serviced normally.
- Ignored acknowledge:
  - Stimulus: mem_ack pulsed in IDLE.
  - Required: no state change and no fill.
- Back-to-back misses:
  - Stimulus: a second miss on the cycle after the FSM returns to IDLE.
  - Required: serviced with identical latency.
